// File: rtl/tqv_ssd1306_spi_master.sv
// SSD1306 4-wire SPI master peripheral for TinyQV: queued {dc,byte} entries are
// shifted out MSB first in SPI mode 0, with a programmable SCK half-period.
module tqv_ssd1306_spi_master #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] DIV_RESET  = 8'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic        data_write,
    input  logic        data_read,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic [7:0]  uo_out,
    output logic        user_interrupt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;

    state_t           r_state;
    logic [8:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_irq_en;
    logic [7:0]       r_div;
    logic [7:0]       r_hdiv;
    logic [7:0]       r_cnt;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit;
    logic             r_cs_n;
    logic             r_sck;
    logic             r_sdi;
    logic             r_dc;

    logic       w_push;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_phase_end;
    logic       w_busy;
    logic [8:0] w_head;
    logic       w_unused;

    assign w_push      = data_write && (address == 6'h00 || address == 6'h04);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_phase_end = (r_cnt == r_hdiv);
    assign w_pop       = !w_empty && ((r_state == IDLE) ||
                         (r_state == HIGH && w_phase_end && r_bit == 3'd0));
    assign w_busy      = (r_state != IDLE) || !w_empty;

    assign data_ready     = 1'b1;
    assign user_interrupt = r_irq_en & ~w_busy;
    assign uo_out         = {3'b000, r_dc, r_cs_n, r_sdi, r_sck, 1'b0};
    assign w_unused       = &{1'b0, data_read, data_in[31:9]};

    // Address bit 2 distinguishes DAT (0x04) from CMD (0x00), so it is the D/C flag.
    always_ff @(posedge clk) begin
        if (w_push && !w_full)
            r_fifo[r_wr_ptr] <= {address[2], data_in[7:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_div      <= DIV_RESET;
            r_irq_en   <= 1'b0;
        end else begin
            if (w_push && !w_full)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push && !w_full) - CNT_W'(w_pop);
            if (w_push && w_full)
                r_overflow <= 1'b1;
            else if (data_write && address == 6'h08 && data_in[2])
                r_overflow <= 1'b0;
            if (data_write && address == 6'h0C) begin
                r_div    <= data_in[7:0];
                r_irq_en <= data_in[8];
            end
        end
    end

    // r_hdiv latches DIV at every phase start so a mid-phase rewrite waits its turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cs_n  <= 1'b1;
            r_sck   <= 1'b0;
            r_sdi   <= 1'b0;
            r_dc    <= 1'b0;
            r_shift <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_hdiv  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_cs_n  <= 1'b0;
                        r_dc    <= w_head[8];
                        r_sdi   <= w_head[7];
                        r_shift <= w_head[7:0];
                        r_bit   <= 3'd7;
                        r_cnt   <= '0;
                        r_hdiv  <= r_div;
                        r_state <= LOW;
                    end
                end
                LOW: begin
                    if (w_phase_end) begin
                        r_sck   <= 1'b1;
                        r_cnt   <= '0;
                        r_hdiv  <= r_div;
                        r_state <= HIGH;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (w_phase_end) begin
                        r_sck  <= 1'b0;
                        r_cnt  <= '0;
                        r_hdiv <= r_div;
                        if (r_bit != 3'd0) begin
                            r_bit   <= r_bit - 3'd1;
                            r_shift <= {r_shift[6:0], 1'b0};
                            r_sdi   <= r_shift[6];
                            r_state <= LOW;
                        end else if (w_pop) begin
                            r_dc    <= w_head[8];
                            r_sdi   <= w_head[7];
                            r_shift <= w_head[7:0];
                            r_bit   <= 3'd7;
                            r_state <= LOW;
                        end else begin
                            r_state <= HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (w_phase_end) begin
                        r_cs_n  <= 1'b1;
                        r_sdi   <= 1'b0;
                        r_dc    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_out = 32'd0;
        case (address)
            6'h08:   data_out = {24'd0, 4'(r_count), r_irq_en, r_overflow, w_full, w_busy};
            6'h0C:   data_out = {23'd0, r_irq_en, r_div};
            default: data_out = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_tqv_ssd1306_spi_master.sv
// Directed bench for the SSD1306 SPI master: register reads, SPI framing at several
// dividers, FIFO overflow, interrupt behaviour and asynchronous reset.
module tb_tqv_ssd1306_spi_master;
    logic        clk;
    logic        rst;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_out;
    logic        data_ready;
    logic [7:0]  uo_out;
    logic        user_interrupt;

    int totalChecks = 0;
    int badChecks   = 0;

    int          mLow;
    int          mRises;
    int          mHighMax;
    int          mLowMax;
    int          mBusyErr;
    int          mIrqErr;
    logic [63:0] mBits;
    logic [63:0] mDc;
    logic        mEndIrq;
    logic        mEndBusy;
    logic        mTimeout;
    logic [31:0] rd;

    tqv_ssd1306_spi_master #(.FIFO_DEPTH(4), .DIV_RESET(8'd1)) dut (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .data_in        (data_in),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .uo_out         (uo_out),
        .user_interrupt (user_interrupt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Register write; call between a falling edge and the next rising edge.
    task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data);
        address    = addr;
        data_in    = data;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic readReg(input logic [5:0] addr, output logic [31:0] value);
        @(negedge clk);
        address = addr;
        #1;
        value = data_out;
    endtask

    // Samples the pads once per cycle until one CS_n low window has closed.
    task automatic monitorTransfer(input int maxCycles);
        logic prevSck;
        int   hiRun;
        int   loRun;
        bit   started;
        bit   done;
        mLow = 0; mRises = 0; mHighMax = 0; mLowMax = 0; mBusyErr = 0; mIrqErr = 0;
        mBits = '0; mDc = '0; mEndIrq = 1'bx; mEndBusy = 1'bx;
        prevSck = 1'b0; hiRun = 0; loRun = 0; started = 0; done = 0;
        for (int c = 0; c < maxCycles && !done; c++) begin
            @(negedge clk);
            #1;
            if (uo_out[3] == 1'b0) begin
                started = 1;
                mLow++;
                if (uo_out[1]) begin
                    hiRun++;
                    loRun = 0;
                    if (hiRun > mHighMax) mHighMax = hiRun;
                end else begin
                    loRun++;
                    hiRun = 0;
                    if (loRun > mLowMax) mLowMax = loRun;
                end
                if (uo_out[1] && !prevSck) begin
                    mRises++;
                    mBits = {mBits[62:0], uo_out[2]};
                    mDc   = {mDc[62:0], uo_out[4]};
                end
                if (address == 6'h08 && data_out[0] !== 1'b1) mBusyErr++;
                if (user_interrupt !== 1'b0) mIrqErr++;
            end else if (started) begin
                done    = 1;
                mEndIrq = user_interrupt;
                if (address == 6'h08) mEndBusy = data_out[0];
            end
            prevSck = uo_out[1];
        end
        mTimeout = !done;
        if (mTimeout) $display("[TB] FAIL timeout: CS_n window did not close within %0d cycles", maxCycles);
    endtask

    initial begin
        rst = 1'b1; address = '0; data_in = '0; data_write = 1'b0; data_read = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("uo_out in reset", 64'(uo_out), 64'h08);
        rst = 1'b0;
        readReg(6'h08, rd);
        checkOutput("status after reset", 64'(rd), 64'h00);
        readReg(6'h0C, rd);
        checkOutput("ctrl after reset", 64'(rd), 64'h001);
        checkOutput("uo_out idle", 64'(uo_out), 64'h08);
        checkOutput("irq after reset", 64'(user_interrupt), 64'h0);

        // Single command byte at the fastest divider.
        applyStimulus(6'h0C, 32'h000);
        fork
            monitorTransfer(100);
            begin
                applyStimulus(6'h00, 32'hAF);
                address = 6'h08;
            end
        join
        checkOutput("cmd AF no timeout", 64'(mTimeout), 64'h0);
        checkOutput("cmd AF cs low cycles", 64'(mLow), 64'd17);
        checkOutput("cmd AF rises", 64'(mRises), 64'd8);
        checkOutput("cmd AF bits", mBits, 64'hAF);
        checkOutput("cmd AF dc", mDc, 64'h00);
        checkOutput("cmd AF busy in window", 64'(mBusyErr), 64'd0);
        checkOutput("cmd AF busy after", 64'(mEndBusy), 64'h0);

        // Two data bytes back to back, H=4.
        applyStimulus(6'h0C, 32'h003);
        fork
            monitorTransfer(300);
            begin
                applyStimulus(6'h04, 32'h55);
                applyStimulus(6'h04, 32'h0F);
            end
        join
        checkOutput("dat 55 0F no timeout", 64'(mTimeout), 64'h0);
        checkOutput("dat 55 0F cs low cycles", 64'(mLow), 64'd132);
        checkOutput("dat 55 0F rises", 64'(mRises), 64'd16);
        checkOutput("dat 55 0F bits", mBits, 64'h550F);
        checkOutput("dat 55 0F dc", mDc, 64'hFFFF);
        checkOutput("dat 55 0F sck high run", 64'(mHighMax), 64'd4);
        checkOutput("dat 55 0F sck low run", 64'(mLowMax), 64'd4);

        // D/C switches at the byte boundary without releasing CS_n.
        applyStimulus(6'h0C, 32'h001);
        fork
            monitorTransfer(200);
            begin
                applyStimulus(6'h04, 32'hFF);
                repeat (5) @(negedge clk);
                applyStimulus(6'h00, 32'h00);
            end
        join
        checkOutput("dat FF cmd 00 no timeout", 64'(mTimeout), 64'h0);
        checkOutput("dat FF cmd 00 cs low cycles", 64'(mLow), 64'd66);
        checkOutput("dat FF cmd 00 rises", 64'(mRises), 64'd16);
        checkOutput("dat FF cmd 00 bits", mBits, 64'hFF00);
        checkOutput("dat FF cmd 00 dc", mDc, 64'hFF00);

        // Overflow: six pushes into a four-entry FIFO while the first byte drains slowly.
        applyStimulus(6'h0C, 32'h0FF);
        fork
            monitorTransfer(21000);
            begin
                for (int i = 1; i <= 6; i++) applyStimulus(6'h04, 32'(i));
                readReg(6'h08, rd);
                checkOutput("status full overflow", 64'(rd), 64'h47);
                applyStimulus(6'h08, 32'h4);
                readReg(6'h08, rd);
                checkOutput("status overflow cleared", 64'(rd), 64'h43);
            end
        join
        checkOutput("overflow no timeout", 64'(mTimeout), 64'h0);
        checkOutput("overflow cs low cycles", 64'(mLow), 64'd20736);
        checkOutput("overflow rises", 64'(mRises), 64'd40);
        checkOutput("overflow bits", mBits, 64'h0102030405);
        readReg(6'h08, rd);
        checkOutput("status after drain", 64'(rd), 64'h00);

        // Interrupt falls on push and returns when CS_n rises.
        applyStimulus(6'h0C, 32'h100);
        readReg(6'h08, rd);
        checkOutput("status irq_en", 64'(rd), 64'h08);
        checkOutput("irq idle enabled", 64'(user_interrupt), 64'h1);
        fork
            monitorTransfer(100);
            begin
                applyStimulus(6'h00, 32'hA5);
                checkOutput("irq after push", 64'(user_interrupt), 64'h0);
            end
        join
        checkOutput("irq A5 no timeout", 64'(mTimeout), 64'h0);
        checkOutput("irq A5 cs low cycles", 64'(mLow), 64'd17);
        checkOutput("irq A5 bits", mBits, 64'hA5);
        checkOutput("irq low in window", 64'(mIrqErr), 64'd0);
        checkOutput("irq after window", 64'(mEndIrq), 64'h1);

        // Asynchronous reset in the middle of a byte.
        applyStimulus(6'h0C, 32'h103);
        applyStimulus(6'h00, 32'hA5);
        repeat (10) @(negedge clk);
        checkOutput("cs low before reset", 64'(uo_out[3]), 64'h0);
        rst = 1'b1;
        #1;
        checkOutput("uo_out on mid reset", 64'(uo_out), 64'h08);
        checkOutput("irq on mid reset", 64'(user_interrupt), 64'h0);
        readReg(6'h08, rd);
        checkOutput("status on mid reset", 64'(rd), 64'h00);
        readReg(6'h0C, rd);
        checkOutput("ctrl on mid reset", 64'(rd), 64'h001);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
